// File: rtl/instruction_fetch_unit_pkg.sv
// Fetch-stage types and constants.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Fetch = 2'd1,
        Drop  = 2'd2
    } fetch_state_t;

    localparam int unsigned INST_W = 32;

endpackage

// File: rtl/instruction_pkg.sv
// Instruction word type shared by fetch, decode and the immediate extender.
package instruction_pkg;

    typedef logic [31:0] instruction_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus and decode handshake seen by the fetch stage.
interface instruction_fetch_unit_if #(
    parameter int N = 64
);
    import instruction_pkg::*;

    logic         mem_cyc;
    logic         mem_stb;
    logic [N-1:0] mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rd_dat;
    logic         inst_valid;
    logic         inst_ready;
    instruction_t instruction;
    logic [N-1:0] inst_pc;

    modport master (
        output mem_cyc, mem_stb, mem_addr, inst_valid, instruction, inst_pc,
        input  mem_ack, mem_rd_dat, inst_ready
    );

    modport slave (
        input  mem_cyc, mem_stb, mem_addr, inst_valid, instruction, inst_pc,
        output mem_ack, mem_rd_dat, inst_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_queue.sv
// Synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
module instruction_queue #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? {PW{1'b0}} : ptr + PW'(1);
    endfunction

    // A full queue still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_s  = pop && (count_r != {CW{1'b0}});
        push_s = push && ((count_r != FULL_COUNT) || pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (count_r == {CW{1'b0}});
    assign full    = (count_r == FULL_COUNT);
    assign count   = count_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: walks the PC over a cyc/stb/ack bus and queues {pc, instruction} for decode.
module instruction_fetch_unit
    import instruction_pkg::*;
    import instruction_fetch_unit_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = {N{1'b0}},
    parameter int           DEPTH    = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      redirect_en,
    input  logic [N-1:0]              redirect_pc,
    instruction_fetch_unit_if.master  bus
);

    localparam int           CW      = $clog2(DEPTH + 1);
    localparam int           OW      = CW + 1;
    localparam logic [N-1:0] PC_STEP = {{(N-3){1'b0}}, 3'b100};

    fetch_state_t        state_r;
    fetch_state_t        state_s;
    logic [N-1:0]        fetch_pc_r;
    logic [N-1:0]        fetch_pc_s;
    logic [N-1:0]        addr_r;
    logic [N-1:0]        addr_s;
    logic [N-1:0]        target_s;
    logic                acked_s;
    logic                push_s;
    logic                pop_s;
    logic                room_s;
    logic [OW-1:0]       occ_after_s;
    logic [CW-1:0]       count_s;
    logic                empty_s;
    logic                unused_full_s;
    logic [N+INST_W-1:0] rd_data_s;
    logic                unused_pc_lsb_s;

    assign target_s        = {redirect_pc[N-1:2], 2'b00};
    assign unused_pc_lsb_s = ^redirect_pc[1:0];

    // Queue traffic; a redirect kills both the acked word and any pop.
    always_comb begin
        acked_s     = (state_r == Fetch) && bus.mem_ack;
        push_s      = acked_s && !redirect_en;
        pop_s       = !empty_s && bus.inst_ready && !redirect_en;
        occ_after_s = {1'b0, count_s} + OW'(push_s) - OW'(pop_s);
        room_s      = (occ_after_s < OW'(DEPTH));
    end

    // Next state, next PC and next bus address.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        addr_s     = addr_r;
        case (state_r)
            Idle: begin
                if (redirect_en || room_s) state_s = Fetch;
                else                       state_s = Idle;
            end
            Fetch: begin
                if (redirect_en)       state_s = bus.mem_ack ? Fetch : Drop;
                else if (bus.mem_ack)  state_s = room_s ? Fetch : Idle;
                else                   state_s = Fetch;
            end
            Drop: begin
                if (bus.mem_ack) state_s = Fetch;
                else             state_s = Drop;
            end
            default: state_s = Idle;
        endcase

        if (redirect_en)  fetch_pc_s = target_s;
        else if (acked_s) fetch_pc_s = fetch_pc_r + PC_STEP;
        else              fetch_pc_s = fetch_pc_r;

        // The abandoned request keeps its address until the slave acks it.
        if (state_s == Drop) addr_s = addr_r;
        else                 addr_s = fetch_pc_s;
    end

    // State, PC and address registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= Idle;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
        end
    end

    instruction_queue #(
        .WIDTH (N + INST_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (redirect_en),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data ({fetch_pc_r, bus.mem_rd_dat}),
        .rd_data (rd_data_s),
        .empty   (empty_s),
        .full    (unused_full_s),
        .count   (count_s)
    );

    assign bus.mem_cyc     = (state_r != Idle);
    assign bus.mem_stb     = (state_r != Idle);
    assign bus.mem_addr    = addr_r;
    assign bus.inst_valid  = !empty_s;
    assign bus.inst_pc     = rd_data_s[N+INST_W-1:INST_W];
    assign bus.instruction = rd_data_s[INST_W-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, streaming, backpressure, redirects, wrap.
module tb_instruction_fetch_unit;
    import instruction_pkg::*;

    localparam int N     = 64;
    localparam int DEPTH = 2;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         redirect_en;
    logic [N-1:0] redirect_pc;
    int           checks   = 0;
    int           failures = 0;

    instruction_fetch_unit_if #(.N(N)) bus ();

    instruction_fetch_unit #(
        .N        (N),
        .RESET_PC (64'h0),
        .DEPTH    (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic stb, input logic [63:0] addr);
        chk({tag, ".cyc"}, {63'd0, bus.mem_cyc}, {63'd0, stb});
        chk({tag, ".stb"}, {63'd0, bus.mem_stb}, {63'd0, stb});
        chk({tag, ".addr"}, bus.mem_addr, addr);
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, ".valid"}, {63'd0, bus.inst_valid}, {63'd0, v});
        if (v) begin
            chk({tag, ".pc"}, bus.inst_pc, pc);
            chk({tag, ".inst"}, {32'd0, bus.instruction}, {32'd0, ins});
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_en    = 1'b0;
        redirect_pc    = 64'h0;
        bus.mem_ack    = 1'b0;
        bus.mem_rd_dat = 32'h0;
        bus.inst_ready = 1'b0;
        step();
        step();
        chk_bus("rst", 1'b0, 64'h0);
        chk("rst.valid", {63'd0, bus.inst_valid}, 64'd0);
        chk("rst.inst", {32'd0, bus.instruction}, 64'd0);
        chk("rst.pc", bus.inst_pc, 64'h0);
        reset_n = 1'b1;
        step();
        chk_bus("rel", 1'b1, 64'h0);
        chk_head("rel", 1'b0, 64'h0, 32'h0);
    endtask

    initial begin
        // 1: reset and first request
        do_reset();

        // 2: streaming, one instruction per cycle
        bus.inst_ready = 1'b1;
        bus.mem_ack    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.mem_rd_dat = 32'h13 + 32'(k);
            step();
            chk_head("stream", 1'b1, 64'(4 * k), 32'h13 + 32'(k));
            chk_bus("stream", 1'b1, 64'(4 * (k + 1)));
        end

        // 3: backpressure fills exactly DEPTH entries
        do_reset();
        bus.inst_ready = 1'b0;
        bus.mem_ack    = 1'b1;
        bus.mem_rd_dat = 32'hB0;
        step();
        chk_head("bp0", 1'b1, 64'h0, 32'hB0);
        chk_bus("bp0", 1'b1, 64'h4);
        bus.mem_rd_dat = 32'hB1;
        step();
        chk_head("bp1", 1'b1, 64'h0, 32'hB0);
        chk_bus("bp1", 1'b0, 64'h8);
        bus.mem_ack = 1'b0;
        step();
        chk_head("bp_hold", 1'b1, 64'h0, 32'hB0);
        chk_bus("bp_hold", 1'b0, 64'h8);
        bus.inst_ready = 1'b1;
        step();
        chk_head("bp_resume", 1'b1, 64'h4, 32'hB1);
        chk_bus("bp_resume", 1'b1, 64'h8);
        bus.mem_ack    = 1'b1;
        bus.mem_rd_dat = 32'hB2;
        step();
        chk_head("bp2", 1'b1, 64'h8, 32'hB2);
        chk_bus("bp2", 1'b1, 64'hC);
        bus.mem_ack = 1'b0;
        step();
        chk_head("bp_drain", 1'b0, 64'h0, 32'h0);
        chk_bus("bp_drain", 1'b1, 64'hC);

        // 4: redirect while awaiting ack
        redirect_en = 1'b1;
        redirect_pc = 64'h1002;
        step();
        redirect_en = 1'b0;
        chk_bus("rd_drop0", 1'b1, 64'hC);
        chk_head("rd_drop0", 1'b0, 64'h0, 32'h0);
        step();
        chk_bus("rd_drop1", 1'b1, 64'hC);
        chk_head("rd_drop1", 1'b0, 64'h0, 32'h0);
        bus.mem_ack    = 1'b1;
        bus.mem_rd_dat = 32'hDEAD;
        step();
        chk_bus("rd_new", 1'b1, 64'h1000);
        chk_head("rd_new", 1'b0, 64'h0, 32'h0);
        bus.inst_ready = 1'b0;
        bus.mem_rd_dat = 32'hC0;
        step();
        chk_head("rd_word", 1'b1, 64'h1000, 32'hC0);
        chk_bus("rd_word", 1'b1, 64'h1004);

        // 5: redirect with pop and ack in the same cycle
        bus.inst_ready = 1'b1;
        bus.mem_rd_dat = 32'hE0;
        redirect_en    = 1'b1;
        redirect_pc    = 64'h2000;
        step();
        chk_head("rpa0", 1'b0, 64'h0, 32'h0);
        chk_bus("rpa0", 1'b1, 64'h2000);
        redirect_en = 1'b0;
        bus.mem_ack = 1'b0;
        step();
        chk_head("rpa1", 1'b0, 64'h0, 32'h0);
        chk_bus("rpa1", 1'b1, 64'h2000);

        // 6: wrap-around at the top of the address space
        redirect_en    = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        bus.mem_ack    = 1'b1;
        bus.mem_rd_dat = 32'hF0;
        step();
        chk_bus("wrap0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk_head("wrap0", 1'b0, 64'h0, 32'h0);
        redirect_en    = 1'b0;
        bus.mem_rd_dat = 32'hF1;
        step();
        chk_head("wrap1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hF1);
        chk_bus("wrap1", 1'b1, 64'h0);
        bus.mem_rd_dat = 32'hF2;
        step();
        chk_head("wrap2", 1'b1, 64'h0, 32'hF2);
        chk_bus("wrap2", 1'b1, 64'h4);

        // asynchronous reset in the middle of a fetch
        bus.mem_ack = 1'b0;
        reset_n     = 1'b0;
        #1;
        chk_bus("async_rst", 1'b0, 64'h0);
        chk("async_rst.valid", {63'd0, bus.inst_valid}, 64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk_bus("restart", 1'b1, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
